// File: rtl/axioma_adc_scan_if.sv
// ADC I/O register port between the scan sequencer (master) and the core I/O arbiter/ADC (slave).
interface axioma_adc_scan_if;
  logic       bus_req;
  logic       bus_gnt;
  logic [5:0] adc_io_addr;
  logic [7:0] adc_io_wdata;
  logic [7:0] adc_io_rdata;
  logic       adc_io_read;
  logic       adc_io_write;

  modport master (
    output bus_req, adc_io_addr, adc_io_wdata, adc_io_read, adc_io_write,
    input  bus_gnt, adc_io_rdata
  );

  modport slave (
    input  bus_req, adc_io_addr, adc_io_wdata, adc_io_read, adc_io_write,
    output bus_gnt, adc_io_rdata
  );
endinterface

// File: rtl/axioma_adc_scan.sv
// Autonomous multi-channel ADC scan sequencer storing right-adjusted 10-bit results per channel.
// Optional ADC_SCAN_AVG_EN: four conversions per channel, stored value is the sum divided by 4.
module axioma_adc_scan #(
  parameter int         NUM_CH  = 8,
  parameter logic [2:0] ADPS    = 3'd7,
  parameter logic [1:0] REFS    = 2'd1,
  parameter int         TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cfg_ch_mask,
  input  logic        cfg_continuous,
  input  logic        start,
  input  logic        abort,
  axioma_adc_scan_if.master bus,
  input  logic [2:0]  res_rd_ch,
  output logic [9:0]  res_rd_data,
  output logic [7:0]  res_valid,
  output logic        busy,
  output logic        scan_done,
  output logic        timeout_err,
  output logic [2:0]  cur_ch
);

  localparam logic [5:0] ADDR_ADCL   = 6'h24;
  localparam logic [5:0] ADDR_ADCH   = 6'h25;
  localparam logic [5:0] ADDR_ADCSRA = 6'h26;
  localparam logic [5:0] ADDR_ADMUX  = 6'h27;
  localparam int         PCW         = $clog2(TIMEOUT + 1);
  localparam logic [PCW-1:0] TIMEOUT_C = PCW'(TIMEOUT);
  localparam logic [7:0] VALID_BITS  = 8'((9'd1 << NUM_CH) - 9'd1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ENABLE, S_SEL, S_START, S_POLL,
    S_RDL, S_RDH, S_CLR, S_NEXT, S_DONE, S_DISABLE
  } state_t;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input int lo);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  state_t         state_r, state_next;
  state_t         fsm_next_s;
  logic [7:0]     mask_r;
  logic [2:0]     cur_ch_r;
  logic [PCW-1:0] poll_cnt_r;
  logic [7:0]     low_r;
  logic [9:0]     result_r [8];
  logic [7:0]     res_valid_r;
  logic           timeout_err_r;
`ifdef ADC_SCAN_AVG_EN
  logic [1:0]     pass_r;
  logic [11:0]    acc_r;
  logic [11:0]    sum_s;
`endif

  logic [7:0] mask_in_s;
  logic [3:0] first_s, next_s, lowest_s;
  logic       start_ok_s;
  logic [9:0] sample_s;

  assign mask_in_s  = cfg_ch_mask & VALID_BITS;
  assign first_s    = find_ch(mask_in_s, 0);
  assign next_s     = find_ch(mask_r, int'(cur_ch_r) + 1);
  assign lowest_s   = find_ch(mask_r, 0);
  assign start_ok_s = (state_r == S_IDLE) && start && !abort && first_s[3];
  assign sample_s   = {bus.adc_io_rdata[1:0], low_r};
`ifdef ADC_SCAN_AVG_EN
  assign sum_s      = acc_r + {2'b00, sample_s};
`endif

  // Next-state and ADC port strobes; access states only act while granted.
  always_comb begin
    fsm_next_s       = state_r;
    bus.bus_req      = 1'b1;
    bus.adc_io_addr  = 6'h00;
    bus.adc_io_wdata = 8'h00;
    bus.adc_io_read  = 1'b0;
    bus.adc_io_write = 1'b0;
    case (state_r)
      S_IDLE: begin
        bus.bus_req = 1'b0;
        if (start_ok_s) fsm_next_s = S_REQ;
        else            fsm_next_s = S_IDLE;
      end
      S_REQ: begin
        if (bus.bus_gnt) fsm_next_s = S_ENABLE;
        else             fsm_next_s = S_REQ;
      end
      S_ENABLE, S_CLR: begin
        if (bus.bus_gnt) begin
          bus.adc_io_write = 1'b1;
          bus.adc_io_addr  = ADDR_ADCSRA;
          bus.adc_io_wdata = {5'b10010, ADPS};
`ifdef ADC_SCAN_AVG_EN
          if (state_r == S_ENABLE)  fsm_next_s = S_SEL;
          else if (pass_r == 2'd3) fsm_next_s = S_NEXT;
          else                      fsm_next_s = S_SEL;
`else
          if (state_r == S_ENABLE) fsm_next_s = S_SEL;
          else                     fsm_next_s = S_NEXT;
`endif
        end else begin
          fsm_next_s = state_r;
        end
      end
      S_SEL: begin
        if (bus.bus_gnt) begin
          bus.adc_io_write = 1'b1;
          bus.adc_io_addr  = ADDR_ADMUX;
          bus.adc_io_wdata = {REFS, 3'b000, cur_ch_r};
          fsm_next_s       = S_START;
        end else begin
          fsm_next_s = S_SEL;
        end
      end
      S_START: begin
        if (bus.bus_gnt) begin
          bus.adc_io_write = 1'b1;
          bus.adc_io_addr  = ADDR_ADCSRA;
          bus.adc_io_wdata = {5'b11000, ADPS};
          fsm_next_s       = S_POLL;
        end else begin
          fsm_next_s = S_START;
        end
      end
      S_POLL: begin
        if (bus.bus_gnt) begin
          bus.adc_io_read = 1'b1;
          bus.adc_io_addr = ADDR_ADCSRA;
          if (bus.adc_io_rdata[4])         fsm_next_s = S_RDL;
          else if (poll_cnt_r == TIMEOUT_C) fsm_next_s = S_NEXT;
          else                              fsm_next_s = S_POLL;
        end else begin
          fsm_next_s = S_POLL;
        end
      end
      S_RDL, S_RDH: begin
        if (bus.bus_gnt) begin
          bus.adc_io_read = 1'b1;
          if (state_r == S_RDL) begin
            bus.adc_io_addr = ADDR_ADCL;
            fsm_next_s      = S_RDH;
          end else begin
            bus.adc_io_addr = ADDR_ADCH;
            fsm_next_s      = S_CLR;
          end
        end else begin
          fsm_next_s = state_r;
        end
      end
      S_NEXT: begin
        if (next_s[3]) fsm_next_s = S_SEL;
        else           fsm_next_s = S_DONE;
      end
      S_DONE: begin
        if (cfg_continuous) fsm_next_s = S_SEL;
        else                fsm_next_s = S_IDLE;
      end
      S_DISABLE: begin
        if (bus.bus_gnt) begin
          bus.adc_io_write = 1'b1;
          bus.adc_io_addr  = ADDR_ADCSRA;
          bus.adc_io_wdata = 8'h00;
          fsm_next_s       = S_IDLE;
        end else begin
          fsm_next_s = S_DISABLE;
        end
      end
      default: begin
        bus.bus_req = 1'b0;
        fsm_next_s  = S_IDLE;
      end
    endcase
    // abort outranks every transition, including a same-cycle start
    if (abort && (state_r != S_IDLE)) state_next = S_DISABLE;
    else                              state_next = fsm_next_s;
  end

  // State register and scan datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      mask_r        <= 8'h00;
      cur_ch_r      <= 3'd0;
      poll_cnt_r    <= '0;
      low_r         <= 8'h00;
      res_valid_r   <= 8'h00;
      timeout_err_r <= 1'b0;
      for (int i = 0; i < 8; i++) result_r[i] <= 10'd0;
`ifdef ADC_SCAN_AVG_EN
      pass_r        <= 2'd0;
      acc_r         <= 12'd0;
`endif
    end else begin
      state_r <= state_next;
      if (start_ok_s) begin
        mask_r        <= mask_in_s;
        cur_ch_r      <= first_s[2:0];
        res_valid_r   <= 8'h00;
        timeout_err_r <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
        pass_r        <= 2'd0;
        acc_r         <= 12'd0;
`endif
      end else if (bus.bus_gnt && (state_r == S_START)) begin
        poll_cnt_r <= '0;
      end else if (bus.bus_gnt && (state_r == S_POLL) && !bus.adc_io_rdata[4]) begin
        if (poll_cnt_r == TIMEOUT_C) timeout_err_r <= 1'b1;
        else                         poll_cnt_r    <= poll_cnt_r + PCW'(1);
      end else if (bus.bus_gnt && (state_r == S_RDL)) begin
        low_r <= bus.adc_io_rdata;
      end else if (bus.bus_gnt && (state_r == S_RDH)) begin
`ifdef ADC_SCAN_AVG_EN
        if (pass_r == 2'd3) begin
          result_r[cur_ch_r]    <= sum_s[11:2];
          res_valid_r[cur_ch_r] <= 1'b1;
        end else begin
          acc_r <= sum_s;
        end
`else
        result_r[cur_ch_r]    <= sample_s;
        res_valid_r[cur_ch_r] <= 1'b1;
`endif
      end else if (bus.bus_gnt && (state_r == S_CLR)) begin
`ifdef ADC_SCAN_AVG_EN
        pass_r <= pass_r + 2'd1;
`else
        low_r  <= low_r;
`endif
      end else if (state_r == S_NEXT) begin
        if (next_s[3]) cur_ch_r <= next_s[2:0];
        else           cur_ch_r <= cur_ch_r;
`ifdef ADC_SCAN_AVG_EN
        pass_r <= 2'd0;
        acc_r  <= 12'd0;
`endif
      end else if ((state_r == S_DONE) && cfg_continuous) begin
        cur_ch_r <= lowest_s[2:0];
      end else begin
        cur_ch_r <= cur_ch_r;
      end
    end
  end

  assign res_rd_data = result_r[res_rd_ch];
  assign res_valid   = res_valid_r;
  assign busy        = (state_r != S_IDLE);
  assign scan_done   = (state_r == S_DONE);
  assign timeout_err = timeout_err_r;
  assign cur_ch      = cur_ch_r;

endmodule
